// File: rtl/keypad_scanner_if.sv
// Keypad matrix signal bundle: column drive, row sense and the debounced key-event outputs.
// Latency: none; this is wiring only.
// Backpressure: none. Key events are fire-and-forget pulses and levels.
// Ports (master = scanner side):
//   col_n     master->slave  active-low column drive, one bit low at a time
//   row_n     slave->master  active-low row sense from the matrix (asynchronous)
//   key_code  master->slave  index of the last pressed key (col*4 + row)
//   key_valid master->slave  one-cycle pulse per accepted single-key press
//   key_down  master->slave  level, high while the accepted single key is held
//   multi_key master->slave  level, high while two or more keys are accepted
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi_key;

  modport master (
    output col_n,
    input  row_n,
    output key_code,
    output key_valid,
    output key_down,
    output multi_key
  );

  modport slave (
    input  col_n,
    output row_n,
    input  key_code,
    input  key_valid,
    input  key_down,
    input  multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, frame debounce, single/multi key press classification.
// Latency: accept at the DEBOUNCE_SCANS-th identical frame end, outputs 1 cycle later.
// Backpressure: none; events are pulses/levels and cannot be stalled.
// Ports:
//   CLK    system clock, rising edge
//   RST_N  synchronous active-low reset
//   kp     keypad_scanner_if master: col_n/row_n to the matrix, key_* events out
module keypad_scanner #(
  parameter int SCAN_DIV       = 16000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  keypad_scanner_if.master   kp
);

  localparam int                DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]        DB       = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_MULTI} state_t;

  logic [3:0]       r_row_s1;
  logic [3:0]       r_row_s2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [3:0]       r_col_n;
  logic [15:0]      r_frame;
  logic [15:0]      r_prev_frame;
  logic [3:0]       r_stable_cnt;
  logic             r_accept;
  state_t           r_state;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_down;
  logic             r_multi_key;

  logic             w_term;
  logic             w_frame_end;
  logic [15:0]      w_new_frame;
  logic             w_same;
  logic [3:0]       w_cnt_nxt;
  logic             w_accept;
  logic             w_zero;
  logic             w_single;
  logic [3:0]       w_idx;
  state_t           w_state_nxt;
  logic [3:0]       w_code_nxt;
  logic             w_valid_nxt;
  logic             w_down_nxt;
  logic             w_multi_nxt;

  assign w_term      = (r_div == DIV_LAST);
  assign w_frame_end = w_term && (r_col == 2'd3);

  // The frame being closed includes the column-3 rows sampled this very cycle.
  always_comb begin
    w_new_frame          = r_frame;
    w_new_frame[12 +: 4] = ~r_row_s2;
  end

  assign w_same    = (w_new_frame == r_prev_frame);
  assign w_cnt_nxt = !w_same ? 4'd1 :
                     (r_stable_cnt == DB) ? DB : (r_stable_cnt + 4'd1);
  // Fire only on the step into DB. A changed frame with DB==1 is its own first (and final) step.
  assign w_accept  = (w_cnt_nxt == DB) && (!w_same || (r_stable_cnt != DB));

  // Scan, synchronizer and debounce datapath.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_row_s1     <= 4'hF;
      r_row_s2     <= 4'hF;
      r_div        <= '0;
      r_col        <= 2'd0;
      r_col_n      <= 4'b1110;
      r_frame      <= 16'd0;
      r_prev_frame <= 16'd0;
      r_stable_cnt <= 4'd0;
      r_accept     <= 1'b0;
    end else begin
      r_row_s1 <= kp.row_n;
      r_row_s2 <= r_row_s1;
      r_accept <= 1'b0;
      if (w_term) begin
        // Sample at the end of the dwell so the driven column has settled.
        r_div                         <= '0;
        r_col                         <= r_col + 2'd1;
        r_col_n                       <= ~(4'b0001 << (r_col + 2'd1));
        r_frame[{r_col, 2'b00} +: 4]  <= ~r_row_s2;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_frame_end) begin
        r_stable_cnt <= w_cnt_nxt;
        r_accept     <= w_accept;
        if (!w_same) begin
          r_prev_frame <= w_new_frame;
        end
      end
    end
  end

  // Classify the accepted frame (held in r_prev_frame while r_accept is high).
  assign w_zero   = (r_prev_frame == 16'd0);
  assign w_single = !w_zero && ((r_prev_frame & (r_prev_frame - 16'd1)) == 16'd0);

  always_comb begin
    w_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_prev_frame[i]) begin
        w_idx = 4'(i);
      end
    end
  end

  // FSM state register (outputs are registered alongside the state).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_multi_key <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_down  <= w_down_nxt;
      r_multi_key <= w_multi_nxt;
    end
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    if (r_accept) begin
      case (r_state)
        S_IDLE: begin
          if (w_single)     w_state_nxt = S_PRESSED;
          else if (!w_zero) w_state_nxt = S_MULTI;
        end
        S_PRESSED: begin
          if (w_zero)         w_state_nxt = S_IDLE;
          else if (!w_single) w_state_nxt = S_MULTI;
        end
        S_MULTI: begin
          // Dropping to one key from MULTI is deliberately not a press.
          if (w_zero) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    w_code_nxt  = r_key_code;
    w_valid_nxt = 1'b0;
    w_down_nxt  = r_key_down;
    w_multi_nxt = r_multi_key;
    if (r_accept) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_code_nxt  = w_idx;
            w_valid_nxt = 1'b1;
            w_down_nxt  = 1'b1;
          end else if (!w_zero) begin
            w_multi_nxt = 1'b1;
          end
        end
        S_PRESSED: begin
          if (w_zero) begin
            w_down_nxt = 1'b0;
          end else if (w_single) begin
            // Rollover: a different single key reports a new press.
            if (w_idx != r_key_code) begin
              w_code_nxt  = w_idx;
              w_valid_nxt = 1'b1;
            end
          end else begin
            w_down_nxt  = 1'b0;
            w_multi_nxt = 1'b1;
          end
        end
        S_MULTI: begin
          if (w_zero) w_multi_nxt = 1'b0;
        end
        default: begin
          w_down_nxt  = 1'b0;
          w_multi_nxt = 1'b0;
        end
      endcase
    end
  end

  assign kp.col_n     = r_col_n;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_down  = r_key_down;
  assign kp.multi_key = r_multi_key;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 matrix model (SCAN_DIV=8, DEBOUNCE_SCANS=3).
// Latency: one frame is 32 cycles; presses are expected within 4 frames + 3 cycles.
// Backpressure: none; key events are counted by a monitor shortly after each rising edge.
module tb_keypad_scanner;

  logic        CLK;
  logic        RST_N;
  logic [15:0] keys;
  logic        watch_down;
  logic        down_low_seen;
  int          n_valid;
  logic [3:0]  last_code;
  int          errors;
  int          checks;
  int          cyc;
  int          base;
  logic [3:0]  exp_col;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV       (8),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .kp    (kif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Diode-less matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    kif.row_n = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4 + r] && !kif.col_n[c]) kif.row_n[r] = 1'b0;
      end
    end
  end

  initial begin
    n_valid       = 0;
    last_code     = 4'd0;
    down_low_seen = 1'b0;
  end

  always @(posedge CLK) begin
    #1;
    if (kif.key_valid) begin
      n_valid   = n_valid + 1;
      last_code = kif.key_code;
    end
    if (watch_down && !kif.key_down) down_low_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input int budget, output int cyc_o);
    int b0;
    b0    = n_valid;
    cyc_o = 0;
    while (n_valid == b0 && cyc_o < budget) begin
      @(negedge CLK);
      cyc_o++;
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    keys       = 16'h0000;
    watch_down = 1'b0;
    RST_N      = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_col_n", kif.col_n, 4'b1110);
    check("rst_outputs", {kif.key_code, kif.key_valid, kif.key_down, kif.multi_key}, 7'd0);

    // Column stepping: each column held exactly 8 cycles
    RST_N = 1'b1;
    for (int j = 0; j < 40; j++) begin
      exp_col = ~(4'b0001 << ((j / 8) % 4));
      check("scan_col_n", kif.col_n, exp_col);
      @(negedge CLK);
    end

    // Single press, key 6
    keys = 16'h0040;
    base = n_valid;
    wait_pulse(131, cyc);
    check("k6_pulse_in_time", n_valid - base, 1);
    check("k6_code", kif.key_code, 4'd6);
    check("k6_down", kif.key_down, 1'b1);
    @(negedge CLK);
    check("k6_valid_one_cycle", kif.key_valid, 1'b0);
    repeat (20 * 32) @(negedge CLK);
    check("k6_no_repeat", n_valid - base, 1);
    check("k6_still_down", kif.key_down, 1'b1);
    keys = 16'h0000;
    cyc  = 0;
    while (kif.key_down && cyc < 131) begin
      @(negedge CLK);
      cyc++;
    end
    check("k6_release_down", kif.key_down, 1'b0);
    check("k6_code_held", kif.key_code, 4'd6);
    check("k6_no_release_pulse", n_valid - base, 1);
    repeat (160) @(negedge CLK);

    // Bounce on key 9, then stable
    base = n_valid;
    repeat (13) begin
      keys[9] = ~keys[9];
      repeat (5) @(negedge CLK);
    end
    keys = 16'h0200;
    repeat (5 * 32) @(negedge CLK);
    check("k9_one_pulse", n_valid - base, 1);
    check("k9_code", last_code, 4'd9);
    keys = 16'h0000;
    repeat (160) @(negedge CLK);

    // Multi-key: keys 1 and 14
    base = n_valid;
    keys = 16'h4002;
    repeat (160) @(negedge CLK);
    check("multi_set", kif.multi_key, 1'b1);
    check("multi_no_pulse", n_valid - base, 0);
    check("multi_no_down", kif.key_down, 1'b0);
    keys = 16'h4000;
    repeat (160) @(negedge CLK);
    check("multi_reduce_stays", kif.multi_key, 1'b1);
    check("multi_reduce_no_pulse", n_valid - base, 0);
    keys = 16'h0000;
    repeat (160) @(negedge CLK);
    check("multi_clear", kif.multi_key, 1'b0);
    check("multi_clear_no_pulse", n_valid - base, 0);

    // Rollover: key 3 then key 12
    base = n_valid;
    keys = 16'h0008;
    wait_pulse(131, cyc);
    check("k3_pulse", n_valid - base, 1);
    check("k3_code", kif.key_code, 4'd3);
    watch_down = 1'b1;
    repeat (40) @(negedge CLK);
    keys = 16'h1000;
    repeat (160) @(negedge CLK);
    check("roll_second_pulse", n_valid - base, 2);
    check("roll_code", kif.key_code, 4'd12);
    check("roll_down_held", kif.key_down, 1'b1);
    check("roll_down_never_low", down_low_seen, 1'b0);
    watch_down = 1'b0;
    keys = 16'h0000;
    repeat (160) @(negedge CLK);

    // Reset mid-hold with key 5
    base = n_valid;
    keys = 16'h0020;
    wait_pulse(131, cyc);
    check("k5_pulse", n_valid - base, 1);
    check("k5_code", kif.key_code, 4'd5);
    RST_N = 1'b0;
    @(negedge CLK);
    check("midrst_col_n", kif.col_n, 4'b1110);
    check("midrst_outputs", {kif.key_code, kif.key_valid, kif.key_down, kif.multi_key}, 7'd0);
    RST_N = 1'b1;
    base  = n_valid;
    wait_pulse(200, cyc);
    check("k5_after_rst_latency", cyc, 97);
    check("k5_after_rst_pulse", n_valid - base, 1);
    check("k5_after_rst_code", kif.key_code, 4'd5);
    keys = 16'h0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
